vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 36 +++
 rtl/vend_inventory.sv | 53 +++++
 rtl/vend_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_vend_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Holds the FSM state enum, coin encodings, credit unit typedef and the
// coin-to-units helper used by vend_controller and vend_inventory.
package vend_pkg;

    localparam int unsigned CREDIT_W = 3;
    localparam int unsigned SLOT_W   = 2;
    localparam int unsigned COIN_W   = 2;

    // Credit held by the machine, in 5-rs units.
    typedef logic [CREDIT_W-1:0] unit_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_PAYOUT  = 2'd3
    } state_e;

    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
    localparam logic [COIN_W-1:0] COIN_10   = 2'b10;
    localparam logic [COIN_W-1:0] COIN_BAD  = 2'b11;

    // Units contributed by a coin code; none/invalid contribute nothing.
    function automatic unit_t coin_value(input logic [COIN_W-1:0] code);
        unit_t v;
        case (code)
            COIN_5:  v = CREDIT_W'(1);
            COIN_10: v = CREDIT_W'(2);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-slot stock counters for the vending controller.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (stock -> STOCK_INIT)
//   i_restock       - reload every slot to STOCK_INIT
//   i_dec           - take one item from slot i_dec_slot
//   i_dec_slot      - slot to decrement
//   o_sold_out_c    - per-slot empty flags, decoded combinationally from stock
module vend_inventory
    import vend_pkg::*;
#(
    parameter int unsigned NSLOT      = 4,
    parameter int unsigned STOCK_INIT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_restock,
    input  logic              i_dec,
    input  logic [SLOT_W-1:0] i_dec_slot,
    output logic [NSLOT-1:0]  o_sold_out_c
);

    localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0] r_stock [NSLOT];

    // Stock counters: restock wins over decrement; never wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else if (i_restock) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else if (i_dec) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                if ((i_dec_slot == SLOT_W'(i)) && (r_stock[i] != '0)) begin
                    r_stock[i] <= r_stock[i] - STOCK_W'(1);
                end
            end
        end
    end

    // Empty flags.
    always_comb begin
        o_sold_out_c = '0;
        for (int i = 0; i < int'(NSLOT); i++) begin
            o_sold_out_c[i] = (r_stock[i] == '0);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending machine controller.
// Accepts 5/10-rs coins up to a credit ceiling, vends one item per select,
// pays change one 5-rs coin at a time, and tracks per-slot stock.
// Optional feature: define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC
// idle cycles in COLLECT.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   in                - coin code this cycle (00 none, 01 5 rs, 10 10 rs, 11 invalid)
//   sel_valid/sel_slot- product select strobe and slot
//   cancel            - refund request (COLLECT only)
//   restock           - refill all slots (IDLE only)
//   disp_ack, chg_ack - motor done / one change coin paid
//   disp_req, disp_slot - dispense request and slot
//   chg_req           - change payout request
//   credit            - held credit in 5-rs units
//   sold_out          - per-slot empty flags
//   coin_rej, sel_err - one-cycle reject / select error pulses
//   busy              - high in VEND or PAYOUT
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned NSLOT       = 4,
    parameter int unsigned PRICE       = 3,
    parameter int unsigned CREDIT_MAX  = 6,
    parameter int unsigned STOCK_INIT  = 7,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COIN_W-1:0] in,
    input  logic              sel_valid,
    input  logic [SLOT_W-1:0] sel_slot,
    input  logic              cancel,
    input  logic              restock,
    input  logic              disp_ack,
    input  logic              chg_ack,
    output logic              disp_req,
    output logic [SLOT_W-1:0] disp_slot,
    output logic              chg_req,
    output logic [CREDIT_W-1:0] credit,
    output logic [NSLOT-1:0]  sold_out,
    output logic              coin_rej,
    output logic              sel_err,
    output logic              busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_e            r_state, w_state_nxt;
    unit_t             r_credit, w_credit_nxt;
    logic [SLOT_W-1:0] r_disp_slot, w_slot_nxt;
    logic              r_disp_req, r_chg_req, r_busy;
    logic              r_coin_rej, w_coin_rej_nxt;
    logic              r_sel_err, w_sel_err_nxt;
    logic              w_dec, w_restock;
    logic [NSLOT-1:0]  w_sold_out;

    logic [SUM_W-1:0]  w_sum;
    logic              w_coin_present, w_coin_ok;
    logic              w_slot_valid, w_slot_empty, w_sel_ok;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
`endif

    vend_inventory #(
        .NSLOT      (NSLOT),
        .STOCK_INIT (STOCK_INIT)
    ) u_inventory (
        .clk          (clk),
        .rst_n        (rst),
        .i_restock    (w_restock),
        .i_dec        (w_dec),
        .i_dec_slot   (r_disp_slot),
        .o_sold_out_c (w_sold_out)
    );

    // Coin qualification: a valid code that keeps credit within the ceiling.
    always_comb begin
        w_sum          = {1'b0, r_credit} + {1'b0, coin_value(in)};
        w_coin_present = (in != COIN_NONE);
        w_coin_ok      = ((in == COIN_5) || (in == COIN_10)) &&
                         (w_sum <= SUM_W'(CREDIT_MAX));
    end

    // Select qualification; out-of-range slots count as invalid.
    always_comb begin
        w_slot_valid = 1'b0;
        w_slot_empty = 1'b1;
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (sel_slot == SLOT_W'(i)) begin
                w_slot_valid = 1'b1;
                w_slot_empty = w_sold_out[i];
            end
        end
        w_sel_ok = w_slot_valid && !w_slot_empty &&
                   (r_credit >= CREDIT_W'(PRICE));
    end

    // Next-state and pulse logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_slot_nxt     = r_disp_slot;
        w_coin_rej_nxt = 1'b0;
        w_sel_err_nxt  = 1'b0;
        w_dec          = 1'b0;
        w_restock      = 1'b0;
`ifdef VEND_TIMEOUT_EN
        w_to_cnt_nxt   = '0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_coin_present) begin
                    if (w_coin_ok) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_state_nxt  = ST_COLLECT;
                    end else begin
                        w_coin_rej_nxt = 1'b1;
                    end
                end
                if (sel_valid) begin
                    w_sel_err_nxt = 1'b1;
                end
                w_restock = restock;
            end

            ST_COLLECT: begin
                if (cancel) begin
                    // Cancel outranks a same-cycle coin and select.
                    w_state_nxt    = ST_PAYOUT;
                    w_coin_rej_nxt = w_coin_present;
                end else if (w_coin_present) begin
                    if (w_coin_ok) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_coin_rej_nxt = 1'b1;
                    end
                    w_sel_err_nxt = sel_valid;
                end else if (sel_valid) begin
                    if (w_sel_ok) begin
                        w_state_nxt  = ST_VEND;
                        w_slot_nxt   = sel_slot;
                        w_credit_nxt = r_credit - CREDIT_W'(PRICE);
                    end else begin
                        w_sel_err_nxt = 1'b1;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = ST_PAYOUT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
`endif
            end

            ST_VEND: begin
                w_coin_rej_nxt = w_coin_present;
                w_sel_err_nxt  = sel_valid;
                if (disp_ack) begin
                    w_dec       = 1'b1;
                    w_state_nxt = (r_credit != '0) ? ST_PAYOUT : ST_IDLE;
                end
            end

            ST_PAYOUT: begin
                w_coin_rej_nxt = w_coin_present;
                w_sel_err_nxt  = sel_valid;
                if (r_credit == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (chg_ack) begin
                    w_credit_nxt = r_credit - CREDIT_W'(1);
                    if (r_credit == CREDIT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    // State and registered outputs; request flags track the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_credit    <= '0;
            r_disp_slot <= '0;
            r_disp_req  <= 1'b0;
            r_chg_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_disp_slot <= w_slot_nxt;
            r_disp_req  <= (w_state_nxt == ST_VEND);
            r_chg_req   <= (w_state_nxt == ST_PAYOUT);
            r_busy      <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_PAYOUT);
            r_coin_rej  <= w_coin_rej_nxt;
            r_sel_err   <= w_sel_err_nxt;
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Idle counter for COLLECT; cleared whenever it is not incremented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign disp_req  = r_disp_req;
    assign disp_slot = r_disp_slot;
    assign chg_req   = r_chg_req;
    assign credit    = r_credit;
    assign sold_out  = w_sold_out;
    assign coin_rej  = r_coin_rej;
    assign sel_err   = r_sel_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller (default parameters).
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid, cancel, restock, disp_ack, chg_ack;
    logic [1:0] sel_slot;
    logic       disp_req, chg_req, coin_rej, sel_err, busy;
    logic [1:0] disp_slot;
    logic [2:0] credit;
    logic [3:0] sold_out;

    integer checks = 0;
    integer errors = 0;

    vend_controller dut (
        .clk       (clk),
        .rst       (rst),
        .in        (coin),
        .sel_valid (sel_valid),
        .sel_slot  (sel_slot),
        .cancel    (cancel),
        .restock   (restock),
        .disp_ack  (disp_ack),
        .chg_ack   (chg_ack),
        .disp_req  (disp_req),
        .disp_slot (disp_slot),
        .chg_req   (chg_req),
        .credit    (credit),
        .sold_out  (sold_out),
        .coin_rej  (coin_rej),
        .sel_err   (sel_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c;
        tick();
        coin = 2'b00;
    endtask

    task automatic vend_slot(input logic [1:0] s);
        put_coin(2'b10);
        put_coin(2'b01);
        sel_valid = 1'b1; sel_slot = s;
        tick();
        sel_valid = 1'b0;
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    task automatic pay_out(input int n);
        chg_ack = 1'b1;
        repeat (n) tick();
        chg_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({disp_req, chg_req, coin_rej, sel_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {disp_req, chg_req, coin_rej, sel_err, busy});
        end
        checks++;
        if (credit !== 3'd0 || disp_slot !== 2'd0) begin
            errors++;
            $display("FAIL reset_credit_slot got %0d/%0d want 0/0", credit, disp_slot);
        end
        checks++;
        if (sold_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sold_out got %b want 0000", sold_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_idle_misc();
        sel_valid = 1'b1; sel_slot = 2'd0; disp_ack = 1'b1; chg_ack = 1'b1;
        tick();
        sel_valid = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
        checks++;
        if (sel_err !== 1'b1 || busy !== 1'b0 || credit !== 3'd0) begin
            errors++;
            $display("FAIL idle_select got sel_err=%b busy=%b credit=%0d want 1 0 0", sel_err, busy, credit);
        end
        put_coin(2'b11);
        checks++;
        if (coin_rej !== 1'b1 || credit !== 3'd0) begin
            errors++;
            $display("FAIL idle_bad_coin got rej=%b credit=%0d want 1 0", coin_rej, credit);
        end
        tick();
        checks++;
        if (coin_rej !== 1'b0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width got rej=%b err=%b want 0 0", coin_rej, sel_err);
        end
    endtask

    task automatic test_vend_exact();
        int hi;
        put_coin(2'b10);
        checks++;
        if (credit !== 3'd2) begin
            errors++;
            $display("FAIL credit_after_10 got %0d want 2", credit);
        end
        put_coin(2'b01);
        checks++;
        if (credit !== 3'd3) begin
            errors++;
            $display("FAIL credit_after_5 got %0d want 3", credit);
        end
        sel_valid = 1'b1; sel_slot = 2'd1;
        tick();
        sel_valid = 1'b0;
        hi = 0;
        for (int c = 0; c < 3; c++) begin
            if (disp_req === 1'b1 && disp_slot === 2'd1) hi++;
            if (c == 2) disp_ack = 1'b1;
            tick();
        end
        disp_ack = 1'b0;
        checks++;
        if (hi != 3) begin
            errors++;
            $display("FAIL disp_req_cycles got %0d want 3", hi);
        end
        checks++;
        if (disp_req !== 1'b0 || busy !== 1'b0 || credit !== 3'd0) begin
            errors++;
            $display("FAIL vend_done got req=%b busy=%b credit=%0d want 0 0 0", disp_req, busy, credit);
        end
    endtask

    task automatic test_change();
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        sel_valid = 1'b1; sel_slot = 2'd0;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (disp_req !== 1'b1 || credit !== 3'd3) begin
            errors++;
            $display("FAIL change_vend got req=%b credit=%0d want 1 3", disp_req, credit);
        end
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        checks++;
        if (chg_req !== 1'b1 || busy !== 1'b1 || credit !== 3'd3) begin
            errors++;
            $display("FAIL payout_entry got chg=%b busy=%b credit=%0d want 1 1 3", chg_req, busy, credit);
        end
        pay_out(1);
        tick();
        checks++;
        if (credit !== 3'd2 || chg_req !== 1'b1) begin
            errors++;
            $display("FAIL payout_gap got credit=%0d chg=%b want 2 1", credit, chg_req);
        end
        pay_out(2);
        checks++;
        if (credit !== 3'd0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL payout_done got credit=%0d chg=%b busy=%b want 0 0 0", credit, chg_req, busy);
        end
    endtask

    task automatic test_coin_reject();
        int n;
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        put_coin(2'b01);
        checks++;
        if (coin_rej !== 1'b1 || credit !== 3'd6) begin
            errors++;
            $display("FAIL ceiling_reject got rej=%b credit=%0d want 1 6", coin_rej, credit);
        end
        cancel = 1'b1; coin = 2'b01;
        tick();
        cancel = 1'b0; coin = 2'b00;
        checks++;
        if (chg_req !== 1'b1 || credit !== 3'd6 || coin_rej !== 1'b1) begin
            errors++;
            $display("FAIL cancel got chg=%b credit=%0d rej=%b want 1 6 1", chg_req, credit, coin_rej);
        end
        chg_ack = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chg_ack = 1'b0;
        checks++;
        if (n != 6 || credit !== 3'd0) begin
            errors++;
            $display("FAIL cancel_refund got cycles=%0d credit=%0d want 6 0", n, credit);
        end
    endtask

    task automatic test_sold_out();
        for (int k = 1; k <= 7; k++) begin
            vend_slot(2'd2);
            if (k >= 6) begin
                checks++;
                if (sold_out[2] !== (k == 7)) begin
                    errors++;
                    $display("FAIL sold_out_vend%0d got %b want %b", k, sold_out[2], (k == 7));
                end
            end
        end
        checks++;
        if (sold_out !== 4'b0100) begin
            errors++;
            $display("FAIL sold_out_vector got %b want 0100", sold_out);
        end
        put_coin(2'b10); put_coin(2'b01);
        sel_valid = 1'b1; sel_slot = 2'd2; restock = 1'b1;
        tick();
        sel_valid = 1'b0; restock = 1'b0;
        checks++;
        if (sel_err !== 1'b1 || busy !== 1'b0 || credit !== 3'd3 || sold_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL empty_select got err=%b busy=%b credit=%0d so=%b want 1 0 3 1",
                     sel_err, busy, credit, sold_out[2]);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        pay_out(3);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        checks++;
        if (sold_out !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restock got so=%b busy=%b want 0000 0", sold_out, busy);
        end
    endtask

    task automatic test_coin_and_select();
        coin = 2'b01; sel_valid = 1'b1; sel_slot = 2'd0;
        tick();
        coin = 2'b00; sel_valid = 1'b0;
        checks++;
        if (credit !== 3'd1 || sel_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coin_with_select got credit=%0d err=%b busy=%b want 1 1 0", credit, sel_err, busy);
        end
        sel_valid = 1'b1; sel_slot = 2'd0;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (sel_err !== 1'b1 || disp_req !== 1'b0 || credit !== 3'd1) begin
            errors++;
            $display("FAIL low_credit_select got err=%b req=%b credit=%0d want 1 0 1", sel_err, disp_req, credit);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        pay_out(1);
        checks++;
        if (busy !== 1'b0 || credit !== 3'd0) begin
            errors++;
            $display("FAIL small_refund got busy=%b credit=%0d want 0 0", busy, credit);
        end
    endtask

    task automatic test_reset_mid_vend();
        put_coin(2'b10); put_coin(2'b01);
        sel_valid = 1'b1; sel_slot = 2'd3;
        tick();
        sel_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (disp_req !== 1'b0 || busy !== 1'b0 || credit !== 3'd0 || disp_slot !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got req=%b busy=%b credit=%0d slot=%0d want 0 0 0 0",
                     disp_req, busy, credit, disp_slot);
        end
        #2 rst = 1'b1;
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || sold_out !== 4'b0000 || chg_req !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got busy=%b so=%b chg=%b want 0 0000 0", busy, sold_out, chg_req);
        end
    endtask

    task automatic test_timeout();
        put_coin(2'b01);
`ifdef VEND_TIMEOUT_EN
        repeat (254) tick();
        checks++;
        if (chg_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got chg=%b want 0", chg_req);
        end
        tick();
        checks++;
        if (chg_req !== 1'b1 || credit !== 3'd1) begin
            errors++;
            $display("FAIL timeout_fire got chg=%b credit=%0d want 1 1", chg_req, credit);
        end
        pay_out(1);
`else
        repeat (300) tick();
        checks++;
        if (chg_req !== 1'b0 || busy !== 1'b0 || credit !== 3'd1) begin
            errors++;
            $display("FAIL no_timeout got chg=%b busy=%b credit=%0d want 0 0 1", chg_req, busy, credit);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        pay_out(1);
`endif
        checks++;
        if (busy !== 1'b0 || credit !== 3'd0) begin
            errors++;
            $display("FAIL timeout_refund got busy=%b credit=%0d want 0 0", busy, credit);
        end
    endtask

    initial begin
        coin = 2'b00; sel_valid = 1'b0; sel_slot = 2'd0; cancel = 1'b0;
        restock = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0; rst = 1'b0;
        test_reset();
        test_idle_misc();
        test_vend_exact();
        test_change();
        test_coin_reject();
        test_sold_out();
        test_coin_and_select();
        test_reset_mid_vend();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
